// File: rtl/pong_score_pkg.sv
// Shared types and constants for the Pong score manager.
// State encoding and the two-bit player code used for both the point
// pulse (increaseScore) and the latched match winner.
package pong_score_pkg;

   // Match flow: wait for the ball to be in play, play a rally, or hold
   // a decided match until a new one is requested.
   typedef enum logic [1:0] {
      SERVE      = 2'd0,
      PLAY       = 2'd1,
      MATCH_OVER = 2'd2
   } state_t;

   // Player codes, shared by the point pulse and the winner output.
   localparam logic [1:0] PT_NONE = 2'b00;
   localparam logic [1:0] PT_P1   = 2'b01;
   localparam logic [1:0] PT_P2   = 2'b10;

endpackage

// File: rtl/pong_score_manager_score_counter.sv
// Saturating score register for one player.
// inc adds one unless the score already sits at MAX_SCORE; clr and reset
// return it to zero. at_max tells the caller the next increment will not
// change the value, so the caller can compute the post-increment score
// without waiting for the register to update.
module score_counter #(
   parameter int SCORE_W   = 7,
   parameter int MAX_SCORE = 99
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   input  logic               clr,
   output logic [SCORE_W-1:0] score,
   output logic               at_max
);

   localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

   assign at_max = (score == MAX_V);

   // Score register: clear wins over increment; increments stop at MAX_V.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         score <= '0;
      end else if (inc && !at_max) begin
         score <= score + SCORE_W'(1);
      end
   end

endmodule

// File: rtl/pong_score_manager.sv
// Two-player Pong score manager.
// Watches the signed ball X coordinate, awards one point per exit past
// either boundary, saturates scores, detects the match winner and then
// freezes until new_match. After every point the ball must be seen back
// inside the field once (SERVE) before another point can be scored, so a
// ball resting outside the field is counted only once.
//
// Optional feature macro: WIN_BY_TWO_EN. When defined, a win also needs
// a two-point lead; reaching MAX_SCORE still wins unconditionally.
//
// state_dbg mirrors the FSM state register for observation.
module pong_score_manager
   import pong_score_pkg::*;
#(
   parameter int BALL_X_W  = 11,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 639,
   parameter int SCORE_W   = 7,
   parameter int MAX_SCORE = 99,
   parameter int WIN_SCORE = 11
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [BALL_X_W-1:0] ball_x,
   input  logic                       new_match,
   output logic [1:0]                 increaseScore,
   output logic [SCORE_W-1:0]         score1,
   output logic [SCORE_W-1:0]         score2,
   output logic [1:0]                 winner,
   output logic                       match_over,
   output logic                       serve_req,
   output logic [1:0]                 state_dbg
);

   localparam logic signed [BALL_X_W-1:0] X_MIN_V = BALL_X_W'(X_MIN);
   localparam logic signed [BALL_X_W-1:0] X_MAX_V = BALL_X_W'(X_MAX);
   localparam logic [SCORE_W-1:0]         MAX_V   = SCORE_W'(MAX_SCORE);
   localparam logic [SCORE_W-1:0]         WIN_V   = SCORE_W'(WIN_SCORE);

   state_t state, state_nxt;
   logic [1:0] pulse_nxt;
   logic [1:0] winner_nxt;
   logic       inc1, inc2, clr;
   logic       at_max1, at_max2;

   // Boundary tests are signed, so a negative coordinate is a left exit.
   logic exit_left, exit_right, in_bounds;
   assign exit_left  = (ball_x < X_MIN_V);
   assign exit_right = (ball_x > X_MAX_V);
   assign in_bounds  = !exit_left && !exit_right;

   // Score each player would hold if they scored on this edge.
   logic [SCORE_W-1:0] s1_new, s2_new;
   assign s1_new = at_max1 ? score1 : score1 + SCORE_W'(1);
   assign s2_new = at_max2 ? score2 : score2 + SCORE_W'(1);

   // Lead requirement: two points over the opponent, or none at all.
   logic lead1, lead2;
`ifdef WIN_BY_TWO_EN
   assign lead1 = ({1'b0, s1_new} >= ({1'b0, score2} + (SCORE_W+1)'(2)));
   assign lead2 = ({1'b0, s2_new} >= ({1'b0, score1} + (SCORE_W+1)'(2)));
`else
   assign lead1 = 1'b1;
   assign lead2 = 1'b1;
`endif

   // Reaching MAX_SCORE always decides the match, which bounds deuce play.
   logic win1, win2;
   assign win1 = ((s1_new >= WIN_V) && lead1) || (s1_new == MAX_V);
   assign win2 = ((s2_new >= WIN_V) && lead2) || (s2_new == MAX_V);

   score_counter #(
      .SCORE_W   (SCORE_W),
      .MAX_SCORE (MAX_SCORE)
   ) u_score1 (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc1),
      .clr    (clr),
      .score  (score1),
      .at_max (at_max1)
   );

   score_counter #(
      .SCORE_W   (SCORE_W),
      .MAX_SCORE (MAX_SCORE)
   ) u_score2 (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc2),
      .clr    (clr),
      .score  (score2),
      .at_max (at_max2)
   );

   // Next-state, point and winner decisions; new_match overrides scoring.
   always_comb begin
      state_nxt  = state;
      pulse_nxt  = PT_NONE;
      winner_nxt = winner;
      inc1       = 1'b0;
      inc2       = 1'b0;
      clr        = 1'b0;
      if (new_match) begin
         clr        = 1'b1;
         winner_nxt = PT_NONE;
         state_nxt  = SERVE;
      end else begin
         case (state)
            SERVE: begin
               if (in_bounds) begin
                  state_nxt = PLAY;
               end
            end
            PLAY: begin
               if (exit_left) begin
                  inc1      = 1'b1;
                  pulse_nxt = PT_P1;
                  if (win1) begin
                     winner_nxt = PT_P1;
                     state_nxt  = MATCH_OVER;
                  end else begin
                     state_nxt = SERVE;
                  end
               end else if (exit_right) begin
                  inc2      = 1'b1;
                  pulse_nxt = PT_P2;
                  if (win2) begin
                     winner_nxt = PT_P2;
                     state_nxt  = MATCH_OVER;
                  end else begin
                     state_nxt = SERVE;
                  end
               end
            end
            MATCH_OVER: begin
               state_nxt = MATCH_OVER;
            end
            default: begin
               state_nxt = SERVE;
            end
         endcase
      end
   end

   // State, point pulse and winner registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= SERVE;
         increaseScore <= PT_NONE;
         winner        <= PT_NONE;
      end else begin
         state         <= state_nxt;
         increaseScore <= pulse_nxt;
         winner        <= winner_nxt;
      end
   end

   assign match_over = (state == MATCH_OVER);
   assign serve_req  = (state == SERVE);
   assign state_dbg  = state;

endmodule

// File: tb/tb_pong_score_manager.sv
// Bench for pong_score_manager: directed vector table, hand-written
// corner sequences, and randomized play checked against a rally model.
module tb_pong_score_manager;

   localparam int W = 20;  // {pulse[2], s1[7], s2[7], winner[2], mo, sr}
`ifdef WIN_BY_TWO_EN
   localparam bit WB2 = 1'b1;
`else
   localparam bit WB2 = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b1;
   logic signed [10:0] ball_x = 11'sd319;
   logic              new_match = 1'b0;
   logic [1:0]        increaseScore, winner, state_dbg;
   logic [6:0]        score1, score2;
   logic              match_over, serve_req;

   logic signed [10:0] ball_x_b = 11'sd319;
   logic              new_match_b = 1'b0;
   logic [1:0]        inc_b, winner_b, state_dbg_b;
   logic [6:0]        score1_b, score2_b;
   logic              match_over_b, serve_req_b;

   pong_score_manager dut (
      .clk(clk), .reset(reset), .ball_x(ball_x), .new_match(new_match),
      .increaseScore(increaseScore), .score1(score1), .score2(score2),
      .winner(winner), .match_over(match_over), .serve_req(serve_req),
      .state_dbg(state_dbg)
   );

   pong_score_manager #(.WIN_SCORE(99), .MAX_SCORE(99)) dut_max (
      .clk(clk), .reset(reset), .ball_x(ball_x_b), .new_match(new_match_b),
      .increaseScore(inc_b), .score1(score1_b), .score2(score2_b),
      .winner(winner_b), .match_over(match_over_b), .serve_req(serve_req_b),
      .state_dbg(state_dbg_b)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A point is possible only once the ball has been seen in the field
   // since the last point ("armed"); a decided match ignores the ball.
   int m_s1, m_s2, m_win, m_pulse;
   bit m_armed;

   function automatic bit m_wins(input int a, input int b);
      return (a >= 11 && (!WB2 || a - b >= 2)) || a == 99;
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_win = 0; m_pulse = 0; m_armed = 1'b0;
   endtask

   task automatic model_step(input int x, input bit nm);
      m_pulse = 0;
      if (nm) begin
         m_s1 = 0; m_s2 = 0; m_win = 0; m_armed = 1'b0;
      end else if (m_win != 0) begin
         // match decided: ignore the ball
      end else if (!m_armed) begin
         if (x >= 0 && x <= 639) m_armed = 1'b1;
      end else if (x < 0) begin
         m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99;
         m_pulse = 1; m_armed = 1'b0;
         if (m_wins(m_s1, m_s2)) m_win = 1;
      end else if (x > 639) begin
         m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99;
         m_pulse = 2; m_armed = 1'b0;
         if (m_wins(m_s2, m_s1)) m_win = 2;
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] model_vec();
      return {2'(m_pulse), 7'(m_s1), 7'(m_s2), 2'(m_win),
              (m_win != 0), (m_win == 0 && !m_armed)};
   endfunction

   task automatic check_model(input string name);
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {increaseScore, score1, score2, winner, match_over, serve_req};
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got pulse=%0d s1=%0d s2=%0d win=%0d mo=%0d sr=%0d expected pulse=%0d s1=%0d s2=%0d win=%0d mo=%0d sr=%0d",
                  name, a[19:18], a[17:11], a[10:4], a[3:2], a[1], a[0],
                  e[19:18], e[17:11], e[10:4], e[3:2], e[1], e[0]);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input int x, input bit nm);
      ball_x = x[10:0];
      new_match = nm;
      model_step(x, nm);
      exp_q.push_back(model_vec());
      @(posedge clk);
      #1;
      new_match = 1'b0;
   endtask

   task automatic cycle(input int x, input bit nm, input string name);
      drive(x, nm);
      check_model(name);
   endtask

   task automatic point(input int p, input string name);
      cycle(319, 1'b0, name);
      cycle((p == 1) ? -1 : 640, 1'b0, name);
   endtask

   task automatic do_reset(input string name);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_val({name, "_pulse"}, int'(increaseScore), 0);
      check_val({name, "_s1"}, int'(score1), 0);
      check_val({name, "_s2"}, int'(score2), 0);
      check_val({name, "_win"}, int'(winner), 0);
      check_val({name, "_mo"}, int'(match_over), 0);
      check_val({name, "_sr"}, int'(serve_req), 1);
      reset = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      int x; bit nm; int pulse; int s1; int s2; int win; bit mo; bit sr;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int x, input bit nm, input int pulse, input int s1,
                      input int s2, input int win, input bit mo, input bit sr);
      vec_t v;
      v.x = x; v.nm = nm; v.pulse = pulse; v.s1 = s1; v.s2 = s2;
      v.win = win; v.mo = mo; v.sr = sr;
      tbl.push_back(v);
   endtask

   initial begin
      ball_x = 11'sd319;
      reset = 1'b1;
      @(posedge clk);
      do_reset("reset");

      add(319, 0, 0, 0, 0, 0, 0, 0);        // served: PLAY
      add(-1,  0, 1, 1, 0, 0, 0, 1);        // left exit
      for (int i = 0; i < 5; i++) add(-1, 0, 0, 1, 0, 0, 0, 1);
      add(319, 0, 0, 1, 0, 0, 0, 0);
      add(640, 0, 2, 1, 1, 0, 0, 1);        // right exit
      add(640, 1, 0, 0, 0, 0, 0, 1);        // new_match beats exit
      for (int i = 1; i <= 11; i++) begin
         add(319, 0, 0, 0, i - 1, 0, 0, 0);
         add(640, 0, 2, 0, i, (i == 11) ? 2 : 0, (i == 11), (i < 11));
      end
      add(640, 0, 0, 0, 11, 2, 1, 0);       // frozen after win
      add(319, 0, 0, 0, 11, 2, 1, 0);
      add(319, 1, 0, 0, 0, 0, 0, 1);        // new match

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].x, tbl[i].nm);
         void'(exp_q.pop_front());
         checks++;
         if (int'(increaseScore) != tbl[i].pulse || int'(score1) != tbl[i].s1 ||
             int'(score2) != tbl[i].s2 || int'(winner) != tbl[i].win ||
             match_over != tbl[i].mo || serve_req != tbl[i].sr) begin
            failures++;
            $display("FAIL vec%0d: got pulse=%0d s1=%0d s2=%0d win=%0d mo=%0d sr=%0d expected pulse=%0d s1=%0d s2=%0d win=%0d mo=%0d sr=%0d",
                     i, increaseScore, score1, score2, winner, match_over, serve_req,
                     tbl[i].pulse, tbl[i].s1, tbl[i].s2, tbl[i].win, tbl[i].mo, tbl[i].sr);
         end
      end

      // Mid-match reset at 5/3.
      for (int i = 0; i < 5; i++) point(1, "mid_p1");
      for (int i = 0; i < 3; i++) point(2, "mid_p2");
      check_val("mid_s1", int'(score1), 5);
      check_val("mid_s2", int'(score2), 3);
      do_reset("mid_reset");

      // Deuce: 10/10, then P2 twice.
      for (int i = 0; i < 10; i++) begin
         point(1, "deuce_p1");
         point(2, "deuce_p2");
      end
      point(2, "deuce_a");
      check_val("deuce_a_s2", int'(score2), 11);
      check_val("deuce_a_win", int'(winner), WB2 ? 0 : 2);
      point(2, "deuce_b");
      check_val("deuce_b_s2", int'(score2), WB2 ? 12 : 11);
      check_val("deuce_b_win", int'(winner), 2);
      cycle(319, 1'b1, "deuce_clear");

      // Randomized play against the model.
      for (int n = 0; n < 1500; n++) begin
         int x, r;
         r = $urandom_range(0, 9);
         case (r)
            0, 1: x = -int'($urandom_range(1, 1024));
            2:    x = 640 + int'($urandom_range(0, 383));
            3: begin
               case ($urandom_range(0, 3))
                  0: x = 0;
                  1: x = 639;
                  2: x = -1;
                  default: x = 640;
               endcase
            end
            default: x = int'($urandom_range(0, 639));
         endcase
         if ($urandom_range(0, 299) == 0) begin
            do_reset("rand_reset");
         end else begin
            cycle(x, ($urandom_range(0, 39) == 0), "rand");
         end
      end

      // WIN_SCORE = MAX_SCORE = 99: P2 wins exactly at saturation.
      do_reset("max_reset");
      for (int i = 0; i < 98; i++) begin
         ball_x_b = 11'sd319; @(posedge clk); #1;
         ball_x_b = 11'sd640; @(posedge clk); #1;
      end
      check_val("max98_s2", int'(score2_b), 98);
      check_val("max98_win", int'(winner_b), 0);
      ball_x_b = 11'sd319; @(posedge clk); #1;
      ball_x_b = 11'sd640; @(posedge clk); #1;
      check_val("max99_pulse", int'(inc_b), 2);
      check_val("max99_s2", int'(score2_b), 99);
      check_val("max99_win", int'(winner_b), 2);
      check_val("max99_mo", int'(match_over_b), 1);
      ball_x_b = 11'sd319; @(posedge clk); #1;
      ball_x_b = 11'sd640; @(posedge clk); #1;
      check_val("max_frozen_pulse", int'(inc_b), 0);
      check_val("max_frozen_s2", int'(score2_b), 99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
